tagged_regfile: RTL and testbench

- Architectural register file with per-register rename state (busy bit plus producer tag) for the out-of-order core. Generalises the single-port valid-flag regfile.
- Provides NRD synchronous read ports and a rename (dispatch) port.
- Writeback is Tomasulo-style over the common data bus (CDB): every busy register whose tag matches the broadcast captures the data.
- Includes same-cycle CDB bypass on reads and a flush for mispredict recovery.

---
 rtl/tagged_regfile.sv | 127 ++++++++++++
 tb/tb_tagged_regfile.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_regfile.sv
// Architectural register file with per-register rename state (busy + producer tag),
// CDB capture by tag match, same-cycle CDB read bypass and mispredict flush.
module tagged_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  ren_en,
   input  logic [IDX_W-1:0]      ren_idx,
   input  logic [TAG_W-1:0]      ren_tag,
   input  logic                  cdb_valid,
   input  logic [TAG_W-1:0]      cdb_tag,
   input  logic [DATA_W-1:0]     cdb_data,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*IDX_W-1:0]  rd_idx,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD*TAG_W-1:0]  rd_tag,
   output logic [NRD-1:0]        rd_valid,
   output logic [IDX_W:0]        busy_cnt
);

   logic [DATA_W-1:0]     data_q [NREGS];
   logic [DATA_W-1:0]     data_d [NREGS];
   logic [TAG_W-1:0]      tag_q  [NREGS];
   logic [TAG_W-1:0]      tag_d  [NREGS];
   logic [NREGS-1:0]      busy_q, busy_d;
   logic [NREGS-1:0]      cdb_hit;
   logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
   logic [NRD*TAG_W-1:0]  rd_tag_q, rd_tag_d;
   logic [NRD-1:0]        rd_valid_q, rd_valid_d;
   logic [IDX_W:0]        busy_cnt_q, busy_cnt_d;
   logic [IDX_W-1:0]      sel;

   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return 32'(idx) < NREGS;
   endfunction

   // Register 0 is never busy, so it can never match and never captures CDB data.
   always_comb begin
      cdb_hit = '0;
      for (int r = 0; r < NREGS; r++) begin
         cdb_hit[r] = cdb_valid && !flush && busy_q[r] && (tag_q[r] == cdb_tag);
      end
   end

   always_comb begin
      data_d     = data_q;
      tag_d      = tag_q;
      busy_d     = busy_q;
      busy_cnt_d = '0;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (cdb_hit[r]) begin
               data_d[r] = cdb_data;
               busy_d[r] = 1'b0;
            end
         end
         // Applied after CDB capture so the newer producer owns the register.
         if (ren_en && (ren_idx != '0) && idx_ok(ren_idx)) begin
            busy_d[ren_idx] = 1'b1;
            tag_d[ren_idx]  = ren_tag;
         end
      end
      for (int r = 0; r < NREGS; r++) begin
         busy_cnt_d = busy_cnt_d + (IDX_W+1)'(busy_d[r]);
      end
   end

   // Reads see post-CDB, pre-rename state.
   always_comb begin
      rd_data_d  = '0;
      rd_tag_d   = '0;
      rd_valid_d = '0;
      sel        = '0;
      for (int p = 0; p < NRD; p++) begin
         sel = rd_idx[p*IDX_W +: IDX_W];
         if (rd_en[p] && idx_ok(sel)) begin
            if (cdb_hit[sel]) begin
               rd_data_d[p*DATA_W +: DATA_W] = cdb_data;
               rd_valid_d[p]                 = 1'b1;
            end else if (busy_q[sel] && !flush) begin
               rd_tag_d[p*TAG_W +: TAG_W] = tag_q[sel];
            end else begin
               rd_data_d[p*DATA_W +: DATA_W] = data_q[sel];
               rd_valid_d[p]                 = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            data_q[r] <= '0;
            tag_q[r]  <= '0;
         end
         busy_q     <= '0;
         rd_data_q  <= '0;
         rd_tag_q   <= '0;
         rd_valid_q <= '0;
         busy_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            data_q[r] <= data_d[r];
            tag_q[r]  <= tag_d[r];
         end
         busy_q     <= busy_d;
         rd_data_q  <= rd_data_d;
         rd_tag_q   <= rd_tag_d;
         rd_valid_q <= rd_valid_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_tag   = rd_tag_q;
   assign rd_valid = rd_valid_q;
   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_tagged_regfile.sv
// Bench for tagged_regfile: directed scenarios against hand-derived constants plus
// randomized traffic against an array-based reference model of the register file.
module tb_tagged_regfile;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int IW = 5;
   localparam int TW = 4;
   localparam int NP = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             ren_en = 1'b0;
   logic [IW-1:0]    ren_idx = '0;
   logic [TW-1:0]    ren_tag = '0;
   logic             cdb_valid = 1'b0;
   logic [TW-1:0]    cdb_tag = '0;
   logic [DW-1:0]    cdb_data = '0;
   logic [NP-1:0]    rd_en = '0;
   logic [NP*IW-1:0] rd_idx = '0;
   logic [NP*DW-1:0] rd_data;
   logic [NP*TW-1:0] rd_tag;
   logic [NP-1:0]    rd_valid;
   logic [IW:0]      busy_cnt;

   logic [DW-1:0]    m_data [NR];
   bit               m_busy [NR];
   int               m_tag  [NR];
   logic [NP*DW-1:0] exp_data;
   logic [NP*TW-1:0] exp_tag;
   logic [NP-1:0]    exp_valid;
   logic [IW:0]      exp_cnt;
   int               n_tests = 0;
   int               n_fail = 0;

   tagged_regfile dut (
      .clk(clk), .rst(rst), .flush(flush), .ren_en(ren_en), .ren_idx(ren_idx),
      .ren_tag(ren_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_tag(rd_tag),
      .rd_valid(rd_valid), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_data[r] = '0;
         m_busy[r] = 1'b0;
         m_tag[r]  = 0;
      end
   endtask

   // Drive one cycle of inputs, predict the registered outputs, advance past the edge.
   task automatic drive(input logic fl, input logic ren, input int ridx, input int rtag,
                        input logic cv, input int ct, input logic [DW-1:0] cd,
                        input logic [NP-1:0] re, input int i0, input int i1);
      int idx [NP];
      int r;
      int n;
      flush = fl; ren_en = ren; ren_idx = IW'(ridx); ren_tag = TW'(rtag);
      cdb_valid = cv; cdb_tag = TW'(ct); cdb_data = cd;
      rd_en = re; rd_idx = {IW'(i1), IW'(i0)};
      idx[0] = i0; idx[1] = i1;
      exp_data = '0; exp_tag = '0; exp_valid = '0;
      for (int p = 0; p < NP; p++) begin
         r = idx[p];
         if (re[p]) begin
            if (!m_busy[r] || fl) begin
               exp_data[p*DW +: DW] = m_data[r];
               exp_valid[p] = 1'b1;
            end else if (cv && m_tag[r] == ct) begin
               exp_data[p*DW +: DW] = cd;
               exp_valid[p] = 1'b1;
            end else begin
               exp_tag[p*TW +: TW] = TW'(m_tag[r]);
            end
         end
      end
      if (fl) begin
         for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
      end else begin
         for (int k = 0; k < NR; k++) begin
            if (m_busy[k] && cv && m_tag[k] == ct) begin
               m_data[k] = cd;
               m_busy[k] = 1'b0;
            end
         end
         if (ren && ridx != 0) begin
            m_busy[ridx] = 1'b1;
            m_tag[ridx]  = rtag;
         end
      end
      n = 0;
      for (int k = 0; k < NR; k++) n += int'(m_busy[k]);
      exp_cnt = (IW+1)'(n);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if ({rd_data, rd_tag, rd_valid, busy_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {rd_data, rd_tag, rd_valid, busy_cnt});
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         drive(0, 0, 0, 0, 0, 0, '0, 2'b11, r, NR - 1 - r);
         n_tests++;
         if (rd_valid !== 2'b11 || rd_data !== '0 || busy_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_read x%0d: got valid=%b data=%h cnt=%0d required 11/0/0",
                     r, rd_valid, rd_data, busy_cnt);
         end
      end
   endtask

   task automatic test_rename_cdb();
      drive(0, 1, 5, 3, 0, 0, '0, 2'b00, 0, 0);
      n_tests++;
      if (busy_cnt !== 6'd1) begin
         n_fail++; $display("FAIL rename_cnt: got %0d required 1", busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b01, 5, 0);
      n_tests++;
      if (rd_valid[0] !== 1'b0 || rd_tag[3:0] !== 4'd3) begin
         n_fail++; $display("FAIL rename_read: got v=%b tag=%0d required 0/3", rd_valid[0], rd_tag[3:0]);
      end
      drive(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 2'b10, 0, 5);
      n_tests++;
      if (rd_valid[1] !== 1'b1 || rd_data[63:32] !== 32'hDEADBEEF || busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL cdb_bypass: got v=%b d=%h cnt=%0d required 1/deadbeef/0",
                  rd_valid[1], rd_data[63:32], busy_cnt);
      end
   endtask

   task automatic test_dispatch_same_cycle();
      drive(0, 1, 7, 9, 0, 0, '0, 2'b01, 7, 0);
      n_tests++;
      if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h0 || busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL dispatch_old: got v=%b d=%h cnt=%0d required 1/0/1",
                  rd_valid[0], rd_data[31:0], busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b01, 7, 0);
      n_tests++;
      if (rd_valid[0] !== 1'b0 || rd_tag[3:0] !== 4'd9) begin
         n_fail++; $display("FAIL dispatch_new: got v=%b tag=%0d required 0/9", rd_valid[0], rd_tag[3:0]);
      end
   endtask

   task automatic test_multi_match();
      drive(0, 1, 4, 2, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 1, 6, 2, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 0, 0, 0, 1, 2, 32'h55, 2'b00, 0, 0);
      n_tests++;
      if (busy_cnt !== 6'd1) begin
         n_fail++; $display("FAIL multi_cnt: got %0d required 1", busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b11, 4, 6);
      n_tests++;
      if (rd_valid !== 2'b11 || rd_data !== {32'h55, 32'h55}) begin
         n_fail++; $display("FAIL multi_read: got v=%b d=%h required 11/55,55", rd_valid, rd_data);
      end
      drive(0, 1, 8, 1, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 1, 8, 5, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h77, 2'b00, 0, 0);
      n_tests++;
      if (busy_cnt !== 6'd2) begin
         n_fail++; $display("FAIL rerename_cnt: got %0d required 2", busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b01, 8, 0);
      n_tests++;
      if (rd_valid[0] !== 1'b0 || rd_tag[3:0] !== 4'd5) begin
         n_fail++; $display("FAIL rerename_read: got v=%b tag=%0d required 0/5", rd_valid[0], rd_tag[3:0]);
      end
   endtask

   task automatic test_rename_vs_cdb();
      drive(0, 1, 10, 6, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 1, 10, 6, 1, 6, 32'h11, 2'b00, 0, 0);
      n_tests++;
      if (busy_cnt !== 6'd3) begin
         n_fail++; $display("FAIL ren_vs_cdb_cnt: got %0d required 3", busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b10, 0, 10);
      n_tests++;
      if (rd_valid[1] !== 1'b0 || rd_tag[7:4] !== 4'd6) begin
         n_fail++; $display("FAIL ren_vs_cdb_read: got v=%b tag=%0d required 0/6", rd_valid[1], rd_tag[7:4]);
      end
      drive(0, 1, 0, 1, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 0, 0, 0, 0, 0, '0, 2'b11, 0, 0);
      n_tests++;
      if (rd_valid !== 2'b11 || rd_data !== '0 || busy_cnt !== 6'd3) begin
         n_fail++;
         $display("FAIL x0_rename: got v=%b d=%h cnt=%0d required 11/0/3", rd_valid, rd_data, busy_cnt);
      end
   endtask

   task automatic test_flush();
      drive(0, 1, 1, 7, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 0, 0, 0, 1, 7, 32'hA5A5, 2'b00, 0, 0);
      drive(0, 1, 1, 11, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 1, 2, 12, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 1, 3, 13, 0, 0, '0, 2'b00, 0, 0);
      n_tests++;
      if (busy_cnt !== 6'd6) begin
         n_fail++; $display("FAIL preflush_cnt: got %0d required 6", busy_cnt);
      end
      drive(1, 1, 9, 1, 1, 11, 32'hFFFF, 2'b01, 1, 0);
      n_tests++;
      if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'hA5A5 || busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL flush: got v=%b d=%h cnt=%0d required 1/a5a5/0",
                  rd_valid[0], rd_data[31:0], busy_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0, 2'b11, 1, 10);
      n_tests++;
      if (rd_valid !== 2'b11 || rd_data !== {32'h11, 32'hA5A5}) begin
         n_fail++; $display("FAIL postflush_read: got v=%b d=%h required 11/11,a5a5", rd_valid, rd_data);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)),
               int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 7)),
               logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)), DW'($urandom),
               NP'($urandom_range(0, 3)), int'($urandom_range(0, NR - 1)),
               int'($urandom_range(0, NR - 1)));
         n_tests++;
         if ({rd_data, rd_tag, rd_valid, busy_cnt} !== {exp_data, exp_tag, exp_valid, exp_cnt}) begin
            n_fail++;
            $display("FAIL random[%0d]: got d=%h t=%h v=%b c=%0d required d=%h t=%h v=%b c=%0d",
                     i, rd_data, rd_tag, rd_valid, busy_cnt, exp_data, exp_tag, exp_valid, exp_cnt);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(0, 1, 12, 4, 0, 0, '0, 2'b00, 0, 0);
      drive(0, 0, 0, 0, 0, 0, '0, 2'b11, 0, 0);
      #2;
      rst = 1'b1;
      flush = 0; ren_en = 0; cdb_valid = 0; rd_en = '0;
      #1;
      n_tests++;
      if ({rd_data, rd_tag, rd_valid, busy_cnt} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b cnt=%0d required 0/0", rd_valid, busy_cnt);
      end
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, '0, 2'b11, 12, 1);
      n_tests++;
      if (rd_valid !== 2'b11 || rd_data !== '0 || busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL post_reset_read: got v=%b d=%h cnt=%0d required 11/0/0",
                  rd_valid, rd_data, busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_rename_cdb();
      test_dispatch_same_cycle();
      test_multi_match();
      test_rename_vs_cdb();
      test_flush();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
